// File: rtl/sram_async_ctrl.sv
// -----------------------------------------------------------------------------
// sram_async_ctrl
//
// Bridges the SoC's single-beat memory request port to a 32-bit asynchronous
// SRAM. Every SRAM pin is driven from a flop, so the pins never glitch.
//
// Access timing in clk cycles, counted from the cycle in which a request is
// accepted:
//   read  : ce_n/oe_n low for RD_WAIT+1 cycles. sram_d_i is captured on the
//           last of those edges. rsp_valid pulses in the following IDLE
//           cycle, RD_WAIT+2 cycles after the accept.
//   write : WR_SETUP cycles of address, data and masks with we_n high. Then
//           WR_PULSE cycles with we_n low. Then WR_HOLD cycles with we_n high
//           again while ce_n and the data are still held.
// The controller can accept a new request in the IDLE cycle that ends an
// access. This guarantees ce_n is high for at least one cycle between
// accesses.
//
// Sleep: when ZZ_IDLE > 0, the controller counts consecutive IDLE cycles with
// no request. After ZZ_IDLE such cycles it drops zz_n. A request seen while
// asleep raises zz_n. The controller then waits WAKE_CYC cycles before it
// takes requests again.
//
// Ports
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   req_valid    in   request present
//   req_ready    out  request accepted on valid & ready (high only in IDLE)
//   req_we       in   1 = write, 0 = read
//   req_adr      in   word address
//   req_wdata    in   write data
//   req_be       in   byte enables (writes only)
//   rsp_valid    out  one-cycle pulse, read data valid
//   rsp_rdata    out  read data, held until the next read response
//   sram_adr     out  SRAM word address
//   sram_ce_n    out  chip enable, active low
//   sram_oe_n    out  output enable, active low
//   sram_we_n    out  write enable, active low
//   sram_zz_n    out  sleep, active low
//   sram_dm_n    out  byte masks, active low
//   sram_d_o     out  data towards the SRAM
//   sram_d_oe    out  drive enable for the shared data bus
//   sram_d_i     in   data from the SRAM
// -----------------------------------------------------------------------------
module sram_async_ctrl #(
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 32,
    parameter int RD_WAIT    = 2,
    parameter int WR_SETUP   = 1,
    parameter int WR_PULSE   = 2,
    parameter int WR_HOLD    = 1,
    parameter int ZZ_IDLE    = 0,
    parameter int WAKE_CYC   = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,

    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDR_WIDTH-1:0]     req_adr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_be,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,

    output logic [ADDR_WIDTH-1:0]     sram_adr,
    output logic                      sram_ce_n,
    output logic                      sram_oe_n,
    output logic                      sram_we_n,
    output logic                      sram_zz_n,
    output logic [DATA_WIDTH/8-1:0]   sram_dm_n,
    output logic [DATA_WIDTH-1:0]     sram_d_o,
    output logic                      sram_d_oe,
    input  logic [DATA_WIDTH-1:0]     sram_d_i
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One down-counter serves all timed phases. Size it for the longest one.
    localparam int CNT_MAX = max2(max2(RD_WAIT, WR_SETUP),
                                  max2(max2(WR_PULSE, WR_HOLD), WAKE_CYC));
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    localparam bit SLEEP_EN = (ZZ_IDLE > 0);
    localparam int IDLE_W   = (ZZ_IDLE > 1) ? $clog2(ZZ_IDLE) : 1;
    // Value of the idle counter during the last idle cycle before sleep.
    localparam logic [IDLE_W-1:0] IDLE_LAST = SLEEP_EN ? IDLE_W'(ZZ_IDLE - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_SLEEP,
        S_WAKE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;       // cycles left in the current timed phase
    logic [IDLE_W-1:0] idle_cnt;  // consecutive request-free IDLE cycles

    // NOTE: all state and every output is updated with non-blocking
    // assignments in this one clocked block. That keeps each pin a clean flop
    // and makes the order of statements inside a branch irrelevant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idle_cnt  <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            sram_adr  <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_zz_n <= 1'b1;
            sram_dm_n <= '1;
            sram_d_o  <= '0;
            sram_d_oe <= 1'b0;
        end else begin
            // rsp_valid is a single-cycle pulse. It is raised only by the
            // last READ edge below.
            rsp_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        // Capture the request. Address, data and masks then
                        // stay frozen for the whole access.
                        req_ready <= 1'b0;
                        idle_cnt  <= '0;
                        sram_adr  <= req_adr;
                        sram_ce_n <= 1'b0;
                        if (req_we) begin
                            state     <= S_WR_SETUP;
                            cnt       <= CNT_W'(WR_SETUP - 1);
                            sram_d_o  <= req_wdata;
                            sram_dm_n <= ~req_be;
                            sram_d_oe <= 1'b1;
                        end else begin
                            state     <= S_READ;
                            cnt       <= CNT_W'(RD_WAIT);
                            sram_oe_n <= 1'b0;
                            sram_dm_n <= '0;
                        end
                    end else if (req_valid) begin
                        // This covers only the first cycle after reset, when
                        // req_ready is still low. A pending request keeps the
                        // controller awake.
                        req_ready <= 1'b1;
                        idle_cnt  <= '0;
                    end else if (SLEEP_EN && idle_cnt == IDLE_LAST) begin
                        state     <= S_SLEEP;
                        req_ready <= 1'b0;
                        sram_zz_n <= 1'b0;
                        idle_cnt  <= '0;
                    end else begin
                        req_ready <= 1'b1;
                        if (SLEEP_EN) begin
                            idle_cnt <= idle_cnt + IDLE_W'(1);
                        end
                    end
                end

                S_READ: begin
                    if (cnt == '0) begin
                        // The SRAM has driven the bus for RD_WAIT+1 cycles.
                        // Capture the data now, then release the chip.
                        state     <= S_IDLE;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= sram_d_i;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_dm_n <= '1;
                        req_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                S_WR_SETUP: begin
                    if (cnt == '0) begin
                        state     <= S_WR_PULSE;
                        cnt       <= CNT_W'(WR_PULSE - 1);
                        sram_we_n <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                S_WR_PULSE: begin
                    if (cnt == '0) begin
                        // we_n rises while ce_n and the data are still held.
                        // The SRAM latches the data on this rising edge.
                        state     <= S_WR_HOLD;
                        cnt       <= CNT_W'(WR_HOLD - 1);
                        sram_we_n <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                S_WR_HOLD: begin
                    if (cnt == '0) begin
                        state     <= S_IDLE;
                        sram_ce_n <= 1'b1;
                        sram_d_oe <= 1'b0;
                        sram_dm_n <= '1;
                        req_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                S_SLEEP: begin
                    if (req_valid) begin
                        state     <= S_WAKE;
                        cnt       <= CNT_W'(WAKE_CYC - 1);
                        sram_zz_n <= 1'b1;
                    end
                end

                S_WAKE: begin
                    // ZZ stays released for WAKE_CYC cycles before the next
                    // request can be accepted.
                    if (cnt == '0) begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                // NOTE: the encoding has one unused value. Recover to a
                // quiescent IDLE rather than leaving that state undefined.
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b0;
                    sram_ce_n <= 1'b1;
                    sram_oe_n <= 1'b1;
                    sram_we_n <= 1'b1;
                    sram_zz_n <= 1'b1;
                    sram_dm_n <= '1;
                    sram_d_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_async_ctrl.sv
// Directed bench for sram_async_ctrl with a word-wide SRAM model. The DUT uses
// default timing (RD_WAIT=2, WR_SETUP=1, WR_PULSE=2, WR_HOLD=1, WAKE_CYC=4)
// with sleep after 8 idle cycles. Inputs change 1 ns after a rising edge, and
// outputs are sampled at the same point.
module tb_sram_async_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [21:0] req_adr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [21:0] sram_adr;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_zz_n;
    logic [3:0]  sram_dm_n;
    logic [31:0] sram_d_o;
    logic        sram_d_oe;
    logic [31:0] sram_d_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_async_ctrl #(.ZZ_IDLE(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_adr   (req_adr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .sram_adr  (sram_adr),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .sram_zz_n (sram_zz_n),
        .sram_dm_n (sram_dm_n),
        .sram_d_o  (sram_d_o),
        .sram_d_oe (sram_d_oe),
        .sram_d_i  (sram_d_i)
    );

    // SRAM model. Reads are combinational while ce_n and oe_n are both low.
    // Writes land on the rising edge of we_n. Unselected reads return a
    // marker value so that mistimed sampling shows up as bad data.
    logic [31:0] mem [0:1023];

    assign sram_d_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_adr[9:0]] : 32'hBAD0_BAD0;

    always @(posedge sram_we_n) begin
        if (!sram_ce_n && sram_d_oe) begin
            for (int b = 0; b < 4; b++) begin
                if (!sram_dm_n[b]) mem[sram_adr[9:0]][8*b +: 8] = sram_d_o[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one cycle. While out of reset, confirm the bus is never driven
    // from both ends and that oe_n is high during a write pulse.
    task automatic tick();
        @(posedge clk);
        #1;
        if (reset_n) begin
            chk("inv_bus", 32'((!sram_oe_n && sram_d_oe) || (!sram_we_n && !sram_oe_n)), 32'd0);
        end
    endtask

    // Present a request and wait for it to be accepted. Returns in the first
    // cycle after the accept.
    task automatic send(input logic we, input logic [21:0] adr, input logic [31:0] wd,
                        input logic [3:0] be);
        int n;
        req_we = we; req_adr = adr; req_wdata = wd; req_be = be; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 40) begin
            tick();
            n++;
        end
        chk("accept_timeout", 32'(n >= 40), 32'd0);
        tick();
        req_valid = 1'b0;
    endtask

    // Called in the first cycle after an accept. lat is the number of cycles
    // from the accept to rsp_valid.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n, ce_lo, we_lo, ce_hi, k, cyc, wc;
        int acc [0:2];
        logic [31:0] rd_q [$];

        // ---- 1: reset values, then ready one clock after release ----
        #2 reset_n = 1'b0;
        #1;
        chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
        chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_zz_n", 32'(sram_zz_n), 32'd1);
        chk("rst_dm_n", 32'(sram_dm_n), 32'hF);
        chk("rst_d_oe", 32'(sram_d_oe), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_adr", 32'(sram_adr), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        chk("rst_ready_low", 32'(req_ready), 32'd0);
        tick();
        chk("rst_ready_high", 32'(req_ready), 32'd1);

        // ---- 2: full-word write, then read it back ----
        send(1'b1, 22'h000123, 32'hDEADBEEF, 4'hF);
        ce_lo = 0; we_lo = 0; n = 0;
        while (sram_ce_n == 1'b0 && n < 20) begin
            ce_lo++;
            if (!sram_we_n) we_lo++;
            tick();
            n++;
        end
        chk("t2_ce_low_cycles", 32'(ce_lo), 32'd4);
        chk("t2_we_low_cycles", 32'(we_lo), 32'd2);
        chk("t2_idle_d_oe", 32'(sram_d_oe), 32'd0);
        chk("t2_idle_dm_n", 32'(sram_dm_n), 32'hF);
        send(1'b0, 22'h000123, 32'h0, 4'h0);
        wait_rsp(lat);
        chk("t2_rd_latency", 32'(lat), 32'd4);
        chk("t2_rdata", rsp_rdata, 32'hDEADBEEF);
        tick();
        chk("t2_rsp_pulse", 32'(rsp_valid), 32'd0);

        // ---- preload through the DUT ----
        send(1'b1, 22'h000010, 32'h11223344, 4'hF);
        send(1'b1, 22'h000000, 32'd1, 4'hF);
        send(1'b1, 22'h000001, 32'd2, 4'hF);
        send(1'b1, 22'h000002, 32'd3, 4'hF);

        // ---- 3: partial write (low two bytes), then read ----
        send(1'b1, 22'h000010, 32'hAABBCCDD, 4'b0011);
        n = 0;
        while (sram_ce_n == 1'b0 && n < 20) begin
            chk("t3_wr_dm_n", 32'(sram_dm_n), 32'hC);
            chk("t3_wr_d_oe", 32'(sram_d_oe), 32'd1);
            tick();
            n++;
        end
        chk("t3_wr_cycles", 32'(n), 32'd4);
        send(1'b0, 22'h000010, 32'h0, 4'h0);
        chk("t3_rd_dm_n", 32'(sram_dm_n), 32'h0);
        chk("t3_rd_d_oe", 32'(sram_d_oe), 32'd0);
        chk("t3_rd_oe_n", 32'(sram_oe_n), 32'd0);
        wait_rsp(lat);
        chk("t3_rdata", rsp_rdata, 32'h1122CCDD);

        // ---- 4: back-to-back reads with req_valid held ----
        acc[0] = 0; acc[1] = 0; acc[2] = 0;
        k = 0; cyc = 0; ce_hi = 0;
        req_we = 1'b0; req_adr = 22'd0; req_valid = 1'b1;
        while (cyc < 40) begin
            logic accepted;
            accepted = req_valid && req_ready;
            if (accepted) begin
                acc[k] = cyc;
                k++;
            end
            tick();
            cyc++;
            if (accepted) begin
                if (k == 3) req_valid = 1'b0;
                else        req_adr = 22'(k);
            end
            if (rsp_valid) rd_q.push_back(rsp_rdata);
            if (rd_q.size() == 3) break;
            if (sram_ce_n) ce_hi++;
        end
        chk("t4_accepts", 32'(k), 32'd3);
        chk("t4_period_1", 32'(acc[1] - acc[0]), 32'd4);
        chk("t4_period_2", 32'(acc[2] - acc[1]), 32'd4);
        chk("t4_ce_high_gaps", 32'(ce_hi), 32'd2);
        chk("t4_rsp_count", 32'(rd_q.size()), 32'd3);
        for (int i = 0; i < rd_q.size(); i++) begin
            chk("t4_rdata", rd_q[i], 32'(i + 1));
        end

        // ---- 5: sleep after 8 idle cycles, wake on request ----
        // This cycle carries the last response. It is the first request-free
        // idle cycle.
        n = 0;
        while (sram_zz_n == 1'b1 && n < 30) begin
            tick();
            n++;
        end
        chk("t5_idle_to_sleep", 32'(n), 32'd8);
        chk("t5_sleep_zz_n", 32'(sram_zz_n), 32'd0);
        chk("t5_sleep_ready", 32'(req_ready), 32'd0);
        req_we = 1'b0; req_adr = 22'h000123; req_valid = 1'b1;
        tick();
        chk("t5_wake_zz_n", 32'(sram_zz_n), 32'd1);
        wc = 0;
        while (!req_ready && wc < 20) begin
            wc++;
            tick();
        end
        chk("t5_wake_cycles", 32'(wc), 32'd4);
        tick();
        req_valid = 1'b0;
        chk("t5_access_ce_n", 32'(sram_ce_n), 32'd0);
        wait_rsp(lat);
        chk("t5_rd_latency", 32'(lat), 32'd4);
        chk("t5_rdata", rsp_rdata, 32'hDEADBEEF);

        // ---- 6: reset asserted during the write pulse ----
        send(1'b1, 22'h000040, 32'h12345678, 4'hF);
        chk("t6_setup_we_n", 32'(sram_we_n), 32'd1);
        tick();
        chk("t6_pulse_we_n", 32'(sram_we_n), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_abort_we_n", 32'(sram_we_n), 32'd1);
        chk("t6_abort_ce_n", 32'(sram_ce_n), 32'd1);
        chk("t6_abort_d_oe", 32'(sram_d_oe), 32'd0);
        chk("t6_abort_ready", 32'(req_ready), 32'd0);
        tick();
        chk("t6_no_rsp_a", 32'(rsp_valid), 32'd0);
        tick();
        chk("t6_no_rsp_b", 32'(rsp_valid), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("t6_ready_after", 32'(req_ready), 32'd1);
        chk("t6_no_rsp_c", 32'(rsp_valid), 32'd0);
        send(1'b0, 22'h000123, 32'h0, 4'h0);
        wait_rsp(lat);
        chk("t6_rd_latency", 32'(lat), 32'd4);
        chk("t6_rdata", rsp_rdata, 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
